// File: rtl/sccb_pkg.sv
`timescale 1ns/1ps
// sccb_pkg: shared FSM state type, sizes and R/W bit encoding for the
// SCCB register slave.
package sccb_pkg;

    localparam int unsigned SCCB_BYTE_W    = 8;
    localparam int unsigned SCCB_REG_DEPTH = 256;

    // R/W bit (LSB of the device byte)
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        SUB,
        SUB_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RD_MACK
    } sccb_state_t;

endpackage

// File: rtl/sccb_line_sync.sv
`timescale 1ns/1ps
// sccb_line_sync: brings SCL/SDA into the clk domain and derives SCL edge
// strobes plus START/STOP conditions. Strobes are combinational from the
// second synchronizer stage and its history flop.
module sccb_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;

    // Two-flop synchronizers plus one history stage; reset to the idle-bus level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    // SCL must be high in both current and previous sample for START/STOP,
    // so a simultaneous SCL/SDA change is never a bus condition.
    always_comb begin
        scl_rise = scl_sync[1] & ~scl_d;
        scl_fall = ~scl_sync[1] & scl_d;
        start    = scl_sync[1] & scl_d & sda_d & ~sda_sync[1];
        stop     = scl_sync[1] & scl_d & ~sda_d & sda_sync[1];
        sda      = sda_sync[1];
    end

endmodule

// File: rtl/sccb_reg_slave.sv
`timescale 1ns/1ps
// sccb_reg_slave: SCCB/I2C responder with a 256 x 8 register file,
// sub-address auto-increment and optional register read-back.
// Define SCCB_SLAVE_READ_EN to build the read path (RDATA/RD_MACK).
module sccb_reg_slave
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h60
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scl,
    input  logic                   sda_in,
    output logic                   sda_oe,
    output logic                   wr_stb,
    output logic [SCCB_BYTE_W-1:0] wr_addr,
    output logic [SCCB_BYTE_W-1:0] wr_data,
    input  logic [SCCB_BYTE_W-1:0] cfg_addr,
    output logic [SCCB_BYTE_W-1:0] cfg_data,
    output logic                   busy
);

    logic scl_rise;
    logic scl_fall;
    logic bus_start;
    logic bus_stop;
    logic sda;

    sccb_line_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (bus_start),
        .stop     (bus_stop),
        .sda      (sda)
    );

    sccb_state_t            state;
    logic [2:0]             bit_cnt;
    logic [SCCB_BYTE_W-2:0] shift;
    logic [SCCB_BYTE_W-1:0] ptr;
    logic [SCCB_BYTE_W-1:0] next_byte;
    logic [SCCB_BYTE_W-1:0] regs [SCCB_REG_DEPTH];

`ifdef SCCB_SLAVE_READ_EN
    logic                   rw;
    logic [SCCB_BYTE_W-1:0] rd_byte;
`endif

    // Byte completed by the bit being sampled on this SCL rise.
    always_comb begin
        next_byte = {shift, sda};
        cfg_data  = regs[cfg_addr];
`ifdef SCCB_SLAVE_READ_EN
        rd_byte   = regs[ptr];
`endif
    end

    // Register file, written one cycle after the strobe from the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SCCB_REG_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_stb) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Protocol FSM with registered bus drive, strobe and busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            ptr     <= '0;
            sda_oe  <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
`ifdef SCCB_SLAVE_READ_EN
            rw      <= RW_WRITE;
`endif
        end else begin
            wr_stb <= 1'b0;
            if (bus_start) begin
                state   <= DEV;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (bus_stop) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;

                    DEV, SUB, WDATA: begin
                        if (scl_rise) begin
                            shift   <= next_byte[SCCB_BYTE_W-2:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (state)
                                    DEV: begin
`ifdef SCCB_SLAVE_READ_EN
                                        if (next_byte[7:1] == DEV_ADDR) begin
                                            rw    <= next_byte[0];
`else
                                        if (next_byte[7:1] == DEV_ADDR && next_byte[0] == RW_WRITE) begin
`endif
                                            state <= DEV_ACK;
                                            busy  <= 1'b1;
                                        end else begin
                                            state <= IDLE;
                                        end
                                    end
                                    SUB: begin
                                        ptr   <= next_byte;
                                        state <= SUB_ACK;
                                    end
                                    default: begin
                                        wr_stb  <= 1'b1;
                                        wr_addr <= ptr;
                                        wr_data <= next_byte;
                                        ptr     <= ptr + 8'd1;
                                        state   <= WDATA_ACK;
                                    end
                                endcase
                            end
                        end
                    end

                    // First SCL fall starts the ACK pulse, the next one ends it.
                    DEV_ACK, SUB_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                case (state)
                                    DEV_ACK: begin
`ifdef SCCB_SLAVE_READ_EN
                                        // Read MSB goes out on the same fall that ends the ACK.
                                        if (rw == RW_READ) begin
                                            sda_oe <= ~rd_byte[7];
                                            state  <= RDATA;
                                        end else begin
                                            state  <= SUB;
                                        end
`else
                                        state <= SUB;
`endif
                                    end
                                    SUB_ACK:  state <= WDATA;
                                    default:  state <= WDATA;
                                endcase
                            end
                        end
                    end

`ifdef SCCB_SLAVE_READ_EN
                    // bit_cnt counts bits already clocked out; each fall presents the next one.
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= RD_MACK;
                            end
                        end else if (scl_fall) begin
                            sda_oe <= ~rd_byte[3'd7 - bit_cnt];
                        end
                    end

                    RD_MACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            ptr    <= ptr + 8'd1;
                        end else if (scl_rise) begin
                            bit_cnt <= '0;
                            state   <= sda ? IDLE : RDATA;
                        end
                    end
`endif

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_reg_slave.sv
`timescale 1ns/1ps
// tb_sccb_reg_slave: directed SCCB master driving the register slave over an
// open-drain bus model, with a write scoreboard fed by the stimulus.
module tb_sccb_reg_slave;

    localparam int unsigned Q = 80;   // quarter SCL period (8 clk cycles)

    logic       clk;
    logic       rst;
    logic       scl;
    logic       m_sda;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_stb;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       busy;

    int         vectors     = 0;
    int         miscompares = 0;
    int         stb_cnt     = 0;
    logic       oe_seen     = 1'b0;
    logic [15:0] exp_q[$];

    sccb_reg_slave #(.DEV_ADDR(7'h60)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .busy     (busy)
    );

    // Open-drain bus: either side can pull low.
    assign sda_in = m_sda & ~sda_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge sda_oe) oe_seen = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard: each strobe pops the next expected {addr,data}.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst && wr_stb) begin
            stb_cnt++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {16'h0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr_data", {16'h0, wr_addr, wr_data}, {16'h0, e});
            end
        end
    end

    task automatic clk_bit(input logic b, output logic s);
        m_sda = b; #(Q);
        scl = 1'b1; #(Q);
        s = sda_in; #(Q);
        scl = 1'b0; #(Q);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; #(Q);
        scl = 1'b1; #(Q);
        m_sda = 1'b0; #(Q);
        scl = 1'b0; #(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #(Q);
        scl = 1'b1; #(Q);
        m_sda = 1'b1; #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(~mack, s);
    endtask

    task automatic peek(input logic [7:0] a, input string tag, input logic [7:0] exp);
        cfg_addr = a; #10;
        check(tag, {24'h0, cfg_data}, {24'h0, exp});
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] rd;
        int         stb_before;

        rst = 1'b1; scl = 1'b1; m_sda = 1'b1; cfg_addr = 8'h00;
        #40;
        check("rst_sda_oe",  {31'h0, sda_oe},  32'h0);
        check("rst_wr_stb",  {31'h0, wr_stb},  32'h0);
        check("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
        check("rst_wr_data", {24'h0, wr_data}, 32'h0);
        check("rst_busy",    {31'h0, busy},    32'h0);
        rst = 1'b0;
        #40;
        peek(8'h11, "rst_reg11", 8'h00);

        // Single write C0/11/04
        bus_start();
        write_byte(8'hC0, ack); check("w1_dev_ack", {31'h0, ack}, 32'h1);
        check("w1_busy", {31'h0, busy}, 32'h1);
        write_byte(8'h11, ack); check("w1_sub_ack", {31'h0, ack}, 32'h1);
        exp_q.push_back({8'h11, 8'h04});
        write_byte(8'h04, ack); check("w1_dat_ack", {31'h0, ack}, 32'h1);
        bus_stop();
        #40;
        check("w1_busy_stop", {31'h0, busy}, 32'h0);
        check("w1_stb_cnt", stb_cnt, 32'd1);
        peek(8'h11, "w1_reg11", 8'h04);

        // Foreign device address, then a valid write
        bus_start();
        oe_seen = 1'b0;
        write_byte(8'hA0, ack); check("nm_ack", {31'h0, ack}, 32'h0);
        check("nm_oe_seen", {31'h0, oe_seen}, 32'h0);
        check("nm_busy", {31'h0, busy}, 32'h0);
        write_byte(8'h14, ack); check("nm_ignored", {31'h0, ack}, 32'h0);
        bus_stop();
        check("nm_stb_cnt", stb_cnt, 32'd1);
        bus_start();
        write_byte(8'hC0, ack); check("w2_dev_ack", {31'h0, ack}, 32'h1);
        write_byte(8'h14, ack); check("w2_sub_ack", {31'h0, ack}, 32'h1);
        exp_q.push_back({8'h14, 8'h20});
        write_byte(8'h20, ack); check("w2_dat_ack", {31'h0, ack}, 32'h1);
        bus_stop();
        #40;
        peek(8'h14, "w2_reg14", 8'h20);

        // Burst with pointer wrap FE -> FF -> 00
        bus_start();
        write_byte(8'hC0, ack); check("b_dev_ack", {31'h0, ack}, 32'h1);
        write_byte(8'hFE, ack); check("b_sub_ack", {31'h0, ack}, 32'h1);
        exp_q.push_back({8'hFE, 8'hAA});
        write_byte(8'hAA, ack); check("b_d0_ack", {31'h0, ack}, 32'h1);
        exp_q.push_back({8'hFF, 8'hBB});
        write_byte(8'hBB, ack); check("b_d1_ack", {31'h0, ack}, 32'h1);
        exp_q.push_back({8'h00, 8'hCC});
        write_byte(8'hCC, ack); check("b_d2_ack", {31'h0, ack}, 32'h1);
        bus_stop();
        #40;
        check("b_stb_cnt", stb_cnt, 32'd5);
        peek(8'hFE, "b_regFE", 8'hAA);
        peek(8'hFF, "b_regFF", 8'hBB);
        peek(8'h00, "b_reg00", 8'hCC);

        // STOP after 4 data bits: partial byte discarded
        stb_before = stb_cnt;
        bus_start();
        write_byte(8'hC0, ack); check("p_dev_ack", {31'h0, ack}, 32'h1);
        write_byte(8'h11, ack); check("p_sub_ack", {31'h0, ack}, 32'h1);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
        bus_stop();
        #40;
        check("p_no_stb", stb_cnt, stb_before);
        check("p_busy", {31'h0, busy}, 32'h0);
        peek(8'h11, "p_reg11_kept", 8'h04);

        // Reset in the middle of a SUB byte
        bus_start();
        write_byte(8'hC0, ack); check("r_dev_ack", {31'h0, ack}, 32'h1);
        for (int i = 0; i < 4; i++) clk_bit(1'b0, s);
        rst = 1'b1;
        #20;
        check("r_sda_oe", {31'h0, sda_oe}, 32'h0);
        check("r_busy",   {31'h0, busy},   32'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
        clk_bit(1'b1, s);
        check("r_no_ack", {31'h0, s}, 32'h1);
        bus_stop();
        #40;
        check("r_no_stb", stb_cnt, stb_before);
        peek(8'h11, "r_reg11", 8'h00);
        peek(8'hFE, "r_regFE", 8'h00);
        peek(8'h00, "r_reg00", 8'h00);

`ifdef SCCB_SLAVE_READ_EN
        // Write 0x40 to 0x39, then read back two bytes via repeated START
        bus_start();
        write_byte(8'hC0, ack); check("rd_w_dev_ack", {31'h0, ack}, 32'h1);
        write_byte(8'h39, ack); check("rd_w_sub_ack", {31'h0, ack}, 32'h1);
        exp_q.push_back({8'h39, 8'h40});
        write_byte(8'h40, ack); check("rd_w_dat_ack", {31'h0, ack}, 32'h1);
        bus_stop();
        bus_start();
        write_byte(8'hC0, ack); check("rd_dev_ack", {31'h0, ack}, 32'h1);
        write_byte(8'h39, ack); check("rd_sub_ack", {31'h0, ack}, 32'h1);
        bus_start();
        write_byte(8'hC1, ack); check("rd_devr_ack", {31'h0, ack}, 32'h1);
        read_byte(1'b1, rd); check("rd_byte0", {24'h0, rd}, 32'h40);
        read_byte(1'b0, rd); check("rd_byte1", {24'h0, rd}, 32'h00);
        #40;
        check("rd_released", {31'h0, sda_oe}, 32'h0);
        bus_stop();
        #40;
        check("rd_busy_stop", {31'h0, busy}, 32'h0);
`else
        // Read request is refused when the read path is not built
        bus_start();
        oe_seen = 1'b0;
        write_byte(8'hC1, ack); check("nr_ack", {31'h0, ack}, 32'h0);
        check("nr_oe_seen", {31'h0, oe_seen}, 32'h0);
        check("nr_busy", {31'h0, busy}, 32'h0);
        bus_stop();
`endif

        #100;
        check("sb_drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sccb_reg_slave.md
# sccb_reg_slave

SCCB/I2C responder holding a 256 x 8 register file, answering the three-phase writes (device address, sub-address, data) issued by the camera-configuration initiator through its bus master. It serves as a bus-functional camera model in system simulation and as an on-FPGA configuration target. It oversamples SCL/SDA on `clk`, detects START/STOP, ACKs matching transactions, writes registers with sub-address auto-increment and optionally returns register contents on reads.

## Interface
- `DEV_ADDR`, 7'h60: 7-bit device address. The 8-bit write form is 0xC0 and the read form is 0xC1.
- `clk` in, 1: system clock; must be ≥ 16x the SCL frequency.
- `rst` in, 1: asynchronous, active-high reset.
- `scl` in, 1: bus clock, asynchronous to `clk`.
- `sda_in` in, 1: bus data as sampled, asynchronous to `clk`.
- `sda_oe` out, 1: 1 pulls SDA low; 0 releases it. Open-drain, so the block never drives high.
- `wr_stb` out, 1: one-cycle pulse per register written.
- `wr_addr` out, 8: register index written; valid with `wr_stb`.
- `wr_data` out, 8: value written; valid with `wr_stb`.
- `cfg_addr` in, 8: host-side read index.
- `cfg_data` out, 8: register[`cfg_addr`]; combinational read.
- `busy` out, 1: high from an address-matched device byte until STOP.

## Operation
- **Line conditioning**
  - `scl`/`sda_in` pass through 2-flop synchronizers and a 1-cycle history register.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - Data bits are sampled on the SCL rising edge.
- **State machine** states: IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK.
  - START from any state: go to DEV, clear the bit counter, `sda_oe`=0. This covers repeated START.
  - STOP from any state: go to IDLE, `sda_oe`=0, `busy`=0.
  - DEV shifts 8 bits MSB first.
    - Bits[7:1]==`DEV_ADDR`: go to DEV_ACK and set `busy`.
    - Otherwise: go to IDLE with no ACK, ignoring the bus until the next START.
  - DEV_ACK: on the SCL falling edge after bit 8, `sda_oe`=1. It is held through the ACK clock and released on the next SCL falling edge.
    - R/W=0: go to SUB.
    - R/W=1: go to RDATA.
  - SUB: 8 bits load the pointer `ptr`, then SUB_ACK (same ACK timing as DEV_ACK), then WDATA.
  - WDATA: on the 8th bit, `reg[ptr]` <= byte and `wr_stb` pulses with `wr_addr`=`ptr`, `wr_data`=byte. Then `ptr` <= `ptr`+1 (8-bit wrap, 0xFF -> 0x00). Then WDATA_ACK, then WDATA again. Burst length is unlimited.
  - RDATA: on the SCL falling edge, `sda_oe` = ~bit of `reg[ptr]`, MSB first. `sda_oe` changes only while SCL is low.
    - After 8 bits, release SDA, `ptr`+1, go to RD_MACK.
    - Master ACK (SDA=0) at SCL rise: go to RDATA with the next byte.
    - Master NACK: go to IDLE.
- **Register file**
  - A write hitting `cfg_addr` is visible on `cfg_data` the cycle after `wr_stb`.
  - The register file and `ptr` keep their values across STOP and START; only `rst` clears them.

## Timing
- Reset values:
  - `sda_oe`=0, `wr_stb`=0, `wr_addr`=0, `wr_data`=0, `busy`=0.
  - All registers 0x00, `ptr`=0x00, state IDLE.
- Input latency is 3 clk cycles from a pin change to the detected event (2 synchronizer stages + edge).
- `wr_stb` asserts 1 cycle after the 8th-bit SCL rise is detected and lasts exactly 1 cycle.
- The ACK drive begins 1 cycle after the detected SCL fall. SDA therefore changes during SCL low, before the master's next rising edge, provided the 16x ratio holds.
- SCL and SDA changing in the same clk cycle are treated as a data change, never as START/STOP.
- `rst` mid-transaction returns to IDLE immediately and releases SDA. The partial byte is discarded; no `wr_stb`.
- STOP or START mid-byte discards the partial byte; no write occurs.

## Configuration
- `SCCB_SLAVE_READ_EN` defined: read path enabled (RDATA, RD_MACK).
- Undefined:
  - A device byte with R/W=1 is not ACKed and the FSM goes to IDLE.
  - RDATA and RD_MACK are not synthesized.
  - `sda_oe` is only ever driven for ACKs.

## Structure
- Package `sccb_pkg` holds:
  - the FSM state enum;
  - `SCCB_BYTE_W`=8 and `SCCB_REG_DEPTH`=256;
  - the R/W bit encoding constants (WRITE=0, READ=1).
- Sub-module `sccb_line_sync`: synchronizers, SCL rise/fall strobes, START/STOP strobes and the synchronized SDA level. It is instantiated once.

## Test plan
- Reset, then write C0/11/04 -> ACK on all three bytes; `wr_stb` once with addr 0x11, data 0x04; `cfg_addr`=0x11 gives `cfg_data`=0x04.
- Device byte 0xA0 -> no ACK; `busy` stays 0; no `wr_stb`; the next valid C0/14/20 transaction is accepted.
- Burst C0/FE/AA/BB/CC -> registers 0xFE=AA, 0xFF=BB, 0x00=CC (wrap); 3 strobes.
- STOP after 4 bits of a data byte, then `rst` pulsed in the middle of a SUB byte -> no write; SDA released; the register file holds its prior values (all 0 after `rst`).
- With `SCCB_SLAVE_READ_EN`: write C0/39/40, then C0/39, repeated START, C1, read 2 bytes with ACK then NACK -> the bus returns 0x40 and then reg 0x3A (0x00); the FSM returns to IDLE.
- Without `SCCB_SLAVE_READ_EN`: C1 -> NACK; `sda_oe` stays 0.
